// File: rtl/timer0_peripheral_pkg.sv
// ---------------------------------------------------------------------------
// timer0_peripheral_pkg
//   Shared memory map and OPTION_REG layout for the TMR0 peripheral, plus
//   the address decode and prescaler ratio helpers.
//   Register addresses are 9-bit regfile addresses. Only bits [7:0] take
//   part in the decode, so each register appears in both banks.
// ---------------------------------------------------------------------------
package timer0_peripheral_pkg;

  localparam logic [8:0] ADDR_TMR0       = 9'h001;
  localparam logic [8:0] ADDR_OPTION_REG = 9'h081;

  // OPTION_REG bit positions
  localparam int OPTION_T0CS  = 5;
  localparam int OPTION_T0SE  = 4;
  localparam int OPTION_PSA   = 3;
  localparam int OPTION_PS_HI = 2;
  localparam int OPTION_PS_LO = 0;

  localparam logic [7:0] OPTION_RESET = 8'hFF;

  typedef enum logic [1:0] {
    REG_NONE   = 2'd0,
    REG_TMR0   = 2'd1,
    REG_OPTION = 2'd2
  } reg_sel_e;

  // Bit 8 (bank select) is deliberately not an input: both banks alias.
  function automatic reg_sel_e decode_addr(input logic [7:0] addr_lo);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr_lo == ADDR_TMR0[7:0])            sel = REG_TMR0;
    else if (addr_lo == ADDR_OPTION_REG[7:0]) sel = REG_OPTION;
    return sel;
  endfunction

  // Terminal count for ratio 1:2^(ps+1), i.e. 2^(ps+1)-1.
  function automatic logic [7:0] ps_mask(input logic [2:0] ps);
    return 8'hFF >> (3'd7 - ps);
  endfunction

endpackage

// File: rtl/timer0_peripheral_prescaler.sv
// ---------------------------------------------------------------------------
// timer0_peripheral_prescaler
//   8-bit prescaler counter advanced by a one-clk source tick. Emits a
//   one-clk output tick on every 2^(PS+1)-th source tick.
// Ports
//   clk      in  core clock
//   rst      in  asynchronous active-low reset
//   i_clear  in  synchronous clear, wins over i_tick
//   i_tick   in  one-clk source tick
//   i_ps     in  ratio select (1:2 .. 1:256)
//   o_tick   out one-clk divided tick, coincident with the terminal source tick
// ---------------------------------------------------------------------------
module timer0_peripheral_prescaler
  import timer0_peripheral_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_tick,
  input  logic [2:0] i_ps,
  output logic       o_tick
);

  logic [7:0] r_count;
  logic       w_hit;

  // ">=" rather than "==" so that lowering PS below the current count
  // (PS changes never clear the counter) terminates at once instead of
  // running the counter round through 255.
  assign w_hit  = (r_count >= ps_mask(i_ps));
  assign o_tick = i_tick & w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 8'h00;
    end else if (i_clear) begin
      r_count <= 8'h00;
    end else if (i_tick) begin
      r_count <= w_hit ? 8'h00 : r_count + 8'h01;
    end
  end

endmodule

// File: rtl/timer0_peripheral.sv
// ---------------------------------------------------------------------------
// timer0_peripheral
//   TMR0 / OPTION_REG peripheral on the core's external peripheral bus.
//   Counts instruction cycles (or T0CKI edges) through an optional
//   prescaler and pulses t0if_set when TMR0 rolls over 0xFF -> 0x00.
//
// Build option
//   TIMER0_EXT_CLK_EN  defined: T0CS/T0SE select a synchronised T0CKI edge
//                      as the count source. Undefined: the source is always
//                      the instruction tick, t0cki is ignored, and
//                      OPTION_REG[5:4] are plain storage.
//
// Ports
//   clk                          in   core clock, rising-edge
//   rst                          in   asynchronous active-low reset
//   extern_peripherals_addr      in   9-bit regfile address
//   extern_peripherals_data_in   in   write data
//   extern_peripherals_wr_en     in   write strobe
//   extern_peripherals_data_out  out  combinational read data, 0 if unmapped
//   t0cki                        in   asynchronous external clock pin
//   t0if_set                     out  one-clk pulse after TMR0 overflow
//   wdt_tick                     out  one-clk prescaler pulse when PSA=1
//
// Bus protocol: there is no valid/ready handshake. A write happens on the
// rising edge where wr_en is high, using addr/data_in from that same cycle;
// the bus never stalls. Reads are purely combinational on addr.
// ---------------------------------------------------------------------------
module timer0_peripheral #(
  parameter int CLKS_PER_INSTR = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int WR_INHIBIT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] extern_peripherals_addr,
  input  logic [7:0] extern_peripherals_data_in,
  input  logic       extern_peripherals_wr_en,
  output logic [7:0] extern_peripherals_data_out,
  input  logic       t0cki,
  output logic       t0if_set,
  output logic       wdt_tick
);

  import timer0_peripheral_pkg::*;

  localparam int PHASE_W = $clog2(CLKS_PER_INSTR);
  localparam int INH_W   = (WR_INHIBIT < 1) ? 1 : $clog2(WR_INHIBIT + 1);

  logic [PHASE_W-1:0] r_phase;
  logic [7:0]         r_tmr0;
  logic [7:0]         r_option;
  logic [INH_W-1:0]   r_inhibit;
  logic               r_t0if;

  reg_sel_e w_sel;
  logic     w_inst_tick;
  logic     w_wr_tmr0;
  logic     w_wr_option;
  logic     w_src_tick;
  logic     w_pre_tick;
  logic     w_psa;
  logic     w_tmr0_inc;
  logic     w_inc_ok;
  logic     w_unused_bits;

  // ---- instruction-cycle phase ----
  assign w_inst_tick = (r_phase == PHASE_W'(CLKS_PER_INSTR - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (w_inst_tick) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PHASE_W'(1);
    end
  end

  // ---- address decode ----
  assign w_sel       = decode_addr(extern_peripherals_addr[7:0]);
  assign w_wr_tmr0   = extern_peripherals_wr_en && (w_sel == REG_TMR0);
  assign w_wr_option = extern_peripherals_wr_en && (w_sel == REG_OPTION);
  assign w_psa       = r_option[OPTION_PSA];

  // ---- count source ----
`ifdef TIMER0_EXT_CLK_EN
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   w_ext_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], t0cki};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // T0SE=1 counts falling edges, T0SE=0 rising edges.
  assign w_ext_tick = r_option[OPTION_T0SE]
                    ? (~r_sync[SYNC_STAGES-1] &  r_sync_prev)
                    : ( r_sync[SYNC_STAGES-1] & ~r_sync_prev);
  assign w_src_tick = r_option[OPTION_T0CS] ? w_ext_tick : w_inst_tick;
  assign w_unused_bits = extern_peripherals_addr[8];
`else
  assign w_src_tick    = w_inst_tick;
  assign w_unused_bits = extern_peripherals_addr[8] ^ t0cki;
`endif

  // ---- prescaler: feeds TMR0 when PSA=0, the watchdog when PSA=1 ----
  timer0_peripheral_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_wr_tmr0 & ~w_psa),
    .i_tick  (w_src_tick),
    .i_ps    (r_option[OPTION_PS_HI:OPTION_PS_LO]),
    .o_tick  (w_pre_tick)
  );

  assign w_tmr0_inc = w_psa ? w_src_tick : w_pre_tick;
  assign wdt_tick   = w_psa & w_pre_tick;

  // A write in the same cycle as an increment wins outright.
  assign w_inc_ok = w_tmr0_inc && (r_inhibit == '0) && !w_wr_tmr0;

  // ---- registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr0    <= 8'h00;
      r_option  <= OPTION_RESET;
      r_inhibit <= '0;
      r_t0if    <= 1'b0;
    end else begin
      r_t0if <= w_inc_ok && (r_tmr0 == 8'hFF);

      if (w_wr_tmr0) begin
        r_tmr0 <= extern_peripherals_data_in;
      end else if (w_inc_ok) begin
        r_tmr0 <= r_tmr0 + 8'h01;
      end

      if (w_wr_option) begin
        r_option <= extern_peripherals_data_in;
      end

      // Inhibit counts instruction cycles, not source ticks.
      if (w_wr_tmr0) begin
        r_inhibit <= INH_W'(WR_INHIBIT);
      end else if (w_inst_tick && (r_inhibit != '0)) begin
        r_inhibit <= r_inhibit - INH_W'(1);
      end
    end
  end

  assign t0if_set = r_t0if;

  // ---- read mux ----
  always_comb begin
    extern_peripherals_data_out = 8'h00;
    case (w_sel)
      REG_TMR0:   extern_peripherals_data_out = r_tmr0;
      REG_OPTION: extern_peripherals_data_out = r_option;
      default:    extern_peripherals_data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_timer0_peripheral.sv
// ---------------------------------------------------------------------------
// tb_timer0_peripheral
//   Directed bench for timer0_peripheral with CLKS_PER_INSTR=4,
//   SYNC_STAGES=2, WR_INHIBIT=2. Inputs change on the falling edge; outputs
//   are read on the falling edge (or 1ns after an address change).
//   n_edges counts rising edges since reset release, so with 4 clks per
//   instruction an edge with n_edges%4==0 is an instruction tick edge.
// ---------------------------------------------------------------------------
module tb_timer0_peripheral;

  logic       clk;
  logic       rst;
  logic [8:0] addr;
  logic [7:0] din;
  logic       wr_en;
  logic [7:0] dout;
  logic       t0cki;
  logic       t0if_set;
  logic       wdt_tick;

  int checks    = 0;
  int errors    = 0;
  int n_edges   = 0;
  int t0if_cnt  = 0;
  int wdt_cnt   = 0;
  int snap_t0if = 0;
  int snap_wdt  = 0;
  int base_inst = 0;

  timer0_peripheral #(
    .CLKS_PER_INSTR (4),
    .SYNC_STAGES    (2),
    .WR_INHIBIT     (2)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .extern_peripherals_addr     (addr),
    .extern_peripherals_data_in  (din),
    .extern_peripherals_wr_en    (wr_en),
    .extern_peripherals_data_out (dout),
    .t0cki                       (t0cki),
    .t0if_set                    (t0if_set),
    .wdt_tick                    (wdt_tick)
  );

  // ---- clock / reset-relative edge count ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) n_edges <= 0;
    else      n_edges <= n_edges + 1;
  end

  // Pulse counters sample the value held during the cycle before each edge.
  always @(posedge clk) begin
    if (t0if_set) t0if_cnt <= t0if_cnt + 1;
    if (wdt_tick) wdt_cnt  <= wdt_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [8:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  // ---- drivers ----
  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    addr  = a;
    din   = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_inst(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(negedge clk);
      if (n_edges % 4 == 0) k++;
    end
  endtask

  task automatic t0cki_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      t0cki = 1'b1;
      repeat (4) @(negedge clk);
      t0cki = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // ---- directed sequence ----
  initial begin
    rst   = 1'b0;
    addr  = 9'h000;
    din   = 8'h00;
    wr_en = 1'b0;
    t0cki = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values and decode
    rd_check("rst_option",      9'h081, 8'hFF);
    rd_check("rst_option_bank", 9'h181, 8'hFF);
    rd_check("rst_tmr0",        9'h001, 8'h00);
    rd_check("rst_unmapped",    9'h005, 8'h00);
    check("rst_t0if", {7'd0, t0if_set}, 8'h00);
    check("rst_wdt",  {7'd0, wdt_tick}, 8'h00);
    @(negedge clk);

    // Release reset and write OPTION=08 (PSA=1, PS=1:2) on edge 1
    rst = 1'b1;
    wr(9'h081, 8'h08);
    rd_check("opt_08_readback", 9'h181, 8'h08);
    rd_check("tmr0_unchanged",  9'h101, 8'h00);

    // TMR0=FD on edge 2; inst edges 4,8 inhibited; 12->FE 16->FF 20->00
    wr(9'h001, 8'hFD);
    snap_t0if = t0if_cnt;
    snap_wdt  = wdt_cnt;
    wait_inst(4);
    rd_check("psa1_tmr0_ff", 9'h001, 8'hFF);
    check("psa1_no_t0if_yet", {7'd0, t0if_set}, 8'h00);
    wait_inst(1);
    rd_check("psa1_overflow", 9'h001, 8'h00);
    check("psa1_t0if_high", {7'd0, t0if_set}, 8'h01);
    @(negedge clk);
    check("psa1_t0if_low", {7'd0, t0if_set}, 8'h00);
    check("psa1_t0if_count", 8'(t0if_cnt - snap_t0if), 8'd1);
    check("psa1_wdt_count",  8'(wdt_cnt - snap_wdt), 8'd2);

    // OPTION=02 (PSA=0, 1:8); TMR0=00 clears prescaler and inhibits 2
    wr(9'h081, 8'h02);
    wr(9'h001, 8'h00);
    snap_wdt = wdt_cnt;
    wait_inst(63);
    rd_check("psa0_tick63", 9'h001, 8'h07);
    wait_inst(1);
    rd_check("psa0_tick64", 9'h001, 8'h08);
    wait_inst(2);
    rd_check("psa0_tick66", 9'h001, 8'h08);
    check("psa0_no_wdt", 8'(wdt_cnt - snap_wdt), 8'd0);

    // Write colliding with an instruction-tick increment
    wr(9'h081, 8'h08);
    while (n_edges % 4 != 3) @(negedge clk);
    wr(9'h001, 8'h10);
    rd_check("collide_write_wins", 9'h001, 8'h10);
    check("collide_no_t0if", {7'd0, t0if_set}, 8'h00);
    wait_inst(2);
    rd_check("collide_inhibited", 9'h001, 8'h10);
    wait_inst(1);
    rd_check("collide_resume", 9'h001, 8'h11);
    base_inst = n_edges / 4;

    // External clock source
    wr(9'h081, 8'h38);
    rd_check("opt_38_readback", 9'h081, 8'h38);
    t0cki_pulses(5);
`ifdef TIMER0_EXT_CLK_EN
    rd_check("ext_falling_5", 9'h001, 8'h16);
    wr(9'h081, 8'h28);
    t0cki = 1'b1;
    repeat (2) @(negedge clk);
    rd_check("ext_rise_latency_2", 9'h001, 8'h16);
    @(negedge clk);
    rd_check("ext_rise_latency_3", 9'h001, 8'h17);
    t0cki = 1'b0;
    repeat (4) @(negedge clk);
    t0cki_pulses(2);
    rd_check("ext_rising_3", 9'h001, 8'h19);
`else
    rd_check("no_ext_inst_only", 9'h001, 8'(17 + n_edges / 4 - base_inst));
`endif

    // Asynchronous reset mid-count
    wr(9'h081, 8'h08);
    wr(9'h001, 8'h7F);
    rd_check("pre_reset_tmr0", 9'h001, 8'h7F);
    snap_t0if = t0if_cnt;
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_t0if", {7'd0, t0if_set}, 8'h00);
    check("async_rst_wdt",  {7'd0, wdt_tick}, 8'h00);
    rd_check("async_rst_tmr0",   9'h001, 8'h00);
    rd_check("async_rst_option", 9'h081, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_no_t0if", 8'(t0if_cnt - snap_t0if), 8'd0);
    rd_check("post_rst_option", 9'h081, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
